// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with iterative shift-add multiply
// Optional restoring divider on opcodes D/E when ALU_PIPE_DIV_EN is defined.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  input  logic [3:0]       ALU_Op_Code,
  input  logic             IN_SIGNED,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_RESULT,
  output logic [3:0]       OUT_FLAGS
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam int M = WIDTH - 1;

`ifdef ALU_PIPE_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif

  state_t state, state_nxt;

  logic             accept;
  logic             produce;
  logic [WIDTH-1:0] res_nxt;
  logic             c_nxt, v_nxt;

  logic [CW-1:0]    cnt;
  logic             last_step;

  logic [2*WIDTH-1:0] mul_acc, mul_a, mul_acc_nxt;
  logic [WIDTH-1:0]   mul_b;

  logic [WIDTH-1:0] as_x, as_y, as_r;
  logic             as_sub;
  logic [WIDTH:0]   as_ext;
  logic             as_v;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic             lt_cmp, gt_cmp;

`ifdef ALU_PIPE_DIV_EN
  logic [WIDTH-1:0] div_rem, div_q, div_b;
  logic             div_is_rem, div_bz;
  logic [WIDTH:0]   div_sh, div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nxt, div_q_nxt;
`endif

  assign IN_READY  = (state == S_IDLE) && (!OUT_VALID || OUT_READY);
  assign accept    = IN_VALID && IN_READY;
  assign last_step = (cnt == LAST);

  // Shared adder/subtractor serving add, sub, inc and dec.
  always_comb begin
    as_x   = IN_A;
    as_y   = IN_B;
    as_sub = 1'b0;
    case (ALU_Op_Code)
      4'h1:    as_sub = 1'b1;
      4'h5:    as_y = ONE;
      4'h6:    begin as_x = IN_B; as_y = ONE; end
      4'h7:    begin as_y = ONE; as_sub = 1'b1; end
      4'h8:    begin as_x = IN_B; as_y = ONE; as_sub = 1'b1; end
      default: ;
    endcase
    as_ext = as_sub ? ({1'b0, as_x} - {1'b0, as_y}) : ({1'b0, as_x} + {1'b0, as_y});
    as_r   = as_ext[WIDTH-1:0];
    as_v   = as_sub ? ((as_x[M] != as_y[M]) && (as_r[M] != as_x[M]))
                    : ((as_x[M] == as_y[M]) && (as_r[M] != as_x[M]));
  end

  always_comb begin
    lt_cmp = IN_SIGNED ? ($signed(IN_A) < $signed(IN_B)) : (IN_A < IN_B);
    gt_cmp = IN_SIGNED ? ($signed(IN_A) > $signed(IN_B)) : (IN_A > IN_B);
  end

  always_comb begin
    alu_res = IN_A;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALU_Op_Code)
      4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h8: begin
        alu_res = as_r;
        alu_c   = as_ext[WIDTH];
        alu_v   = as_v;
      end
      4'h2: alu_res = '0;
      4'h3: begin
        alu_res = {IN_A[WIDTH-2:0], 1'b0};
        alu_c   = IN_A[M];
      end
      4'h4: begin
        alu_res = {IN_SIGNED & IN_A[M], IN_A[WIDTH-1:1]};
        alu_c   = IN_A[0];
      end
      4'h9: alu_res = WIDTH'(IN_A == IN_B);
      4'hA: alu_res = WIDTH'(gt_cmp);
      4'hB: alu_res = WIDTH'(lt_cmp);
      4'hC: alu_res = WIDTH'(IN_A != IN_B);
      default: ;
    endcase
  end

  assign mul_acc_nxt = mul_acc + (mul_b[0] ? mul_a : '0);

`ifdef ALU_PIPE_DIV_EN
  // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
  always_comb begin
    div_sh      = {div_rem, div_q[M]};
    div_sub     = div_sh - {1'b0, div_b};
    div_ge      = (div_sh >= {1'b0, div_b});
    div_rem_nxt = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_q_nxt   = {div_q[WIDTH-2:0], div_ge};
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    produce   = 1'b0;
    res_nxt   = alu_res;
    c_nxt     = alu_c;
    v_nxt     = alu_v;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (ALU_Op_Code == 4'h2) state_nxt = S_MUL;
`ifdef ALU_PIPE_DIV_EN
          else if (ALU_Op_Code == 4'hD || ALU_Op_Code == 4'hE) state_nxt = S_DIV;
`endif
          else produce = 1'b1;
        end
      end
      S_MUL: begin
        if (last_step) begin
          state_nxt = S_IDLE;
          produce   = 1'b1;
          res_nxt   = mul_acc_nxt[WIDTH-1:0];
          c_nxt     = |mul_acc_nxt[2*WIDTH-1:WIDTH];
          v_nxt     = 1'b0;
        end
      end
`ifdef ALU_PIPE_DIV_EN
      S_DIV: begin
        if (last_step) begin
          state_nxt = S_IDLE;
          produce   = 1'b1;
          res_nxt   = div_is_rem ? div_rem_nxt : div_q_nxt;
          c_nxt     = div_bz;
          v_nxt     = 1'b0;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt     <= '0;
      mul_acc <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
`ifdef ALU_PIPE_DIV_EN
      div_rem    <= '0;
      div_q      <= '0;
      div_b      <= '0;
      div_is_rem <= 1'b0;
      div_bz     <= 1'b0;
`endif
    end else if (accept) begin
      cnt     <= '0;
      mul_acc <= '0;
      mul_a   <= {{WIDTH{1'b0}}, IN_A};
      mul_b   <= IN_B;
`ifdef ALU_PIPE_DIV_EN
      div_rem    <= '0;
      div_q      <= IN_A;
      div_b      <= IN_B;
      div_is_rem <= (ALU_Op_Code == 4'hE);
      div_bz     <= (IN_B == '0);
`endif
    end else if (state == S_MUL) begin
      cnt     <= cnt + 1'b1;
      mul_acc <= mul_acc_nxt;
      mul_a   <= {mul_a[2*WIDTH-2:0], 1'b0};
      mul_b   <= {1'b0, mul_b[WIDTH-1:1]};
`ifdef ALU_PIPE_DIV_EN
    end else if (state == S_DIV) begin
      cnt     <= cnt + 1'b1;
      div_rem <= div_rem_nxt;
      div_q   <= div_q_nxt;
`endif
    end
  end

  // Result register: frozen while the consumer stalls.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      OUT_VALID  <= 1'b0;
      OUT_RESULT <= '0;
      OUT_FLAGS  <= '0;
    end else if (produce) begin
      OUT_VALID  <= 1'b1;
      OUT_RESULT <= res_nxt;
      OUT_FLAGS  <= {res_nxt[M], v_nxt, c_nxt, (res_nxt == '0)};
    end else if (OUT_READY) begin
      OUT_VALID  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe (WIDTH=8)
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic [3:0] op;
  logic       in_signed;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [3:0] out_flags;

  int checks = 0;
  int errors = 0;
  int lat;
  int rdy_hi;
  int seen;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .CLK(clk), .RESET_N(reset_n),
    .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_A(in_a), .IN_B(in_b), .ALU_Op_Code(op), .IN_SIGNED(in_signed),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_RESULT(out_result), .OUT_FLAGS(out_flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one bundle from a negedge and returns at the negedge after acceptance.
  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input logic s);
    int waited;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) chk("issue_timeout", 32'(in_ready), 32'd1);
    op = o; in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts cycles from acceptance to OUT_VALID and IN_READY-high cycles meanwhile.
  task automatic wait_result(output int l, output int r);
    l = 1;
    r = 0;
    while (!out_valid && l < 40) begin
      if (in_ready) r++;
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; op = '0; in_signed = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(out_result), 32'h00);
    chk("rst_flags", 32'(out_flags), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    issue(4'h0, 8'hF0, 8'h20, 1'b0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_result", 32'(out_result), 32'h10);
    chk("add_flags", 32'(out_flags), 32'b0010);
    @(negedge clk);
    chk("add_valid_drop", 32'(out_valid), 32'd0);

    issue(4'h1, 8'h80, 8'h01, 1'b0);
    chk("sub_result", 32'(out_result), 32'h7F);
    chk("sub_flags", 32'(out_flags), 32'b0100);
    issue(4'hA, 8'hFF, 8'h01, 1'b1);
    chk("gt_signed", 32'(out_result), 32'h00);
    chk("gt_signed_flags", 32'(out_flags), 32'b0001);
    issue(4'hA, 8'hFF, 8'h01, 1'b0);
    chk("gt_unsigned", 32'(out_result), 32'h01);
    chk("b2b_valid", 32'(out_valid), 32'd1);

    issue(4'h4, 8'h81, 8'h00, 1'b1);
    chk("asr_result", 32'(out_result), 32'hC0);
    chk("asr_flags", 32'(out_flags), 32'b1010);
    issue(4'h4, 8'h81, 8'h00, 1'b0);
    chk("lsr_result", 32'(out_result), 32'h40);
    chk("lsr_flags", 32'(out_flags), 32'b0010);
    issue(4'h3, 8'h81, 8'h00, 1'b0);
    chk("shl_result", 32'(out_result), 32'h02);
    chk("shl_flags", 32'(out_flags), 32'b0010);
    issue(4'h5, 8'h7F, 8'h00, 1'b0);
    chk("inc_result", 32'(out_result), 32'h80);
    chk("inc_flags", 32'(out_flags), 32'b1100);
    issue(4'h8, 8'h11, 8'h00, 1'b0);
    chk("dec_b_result", 32'(out_result), 32'hFF);
    chk("dec_b_flags", 32'(out_flags), 32'b1010);
    issue(4'hB, 8'h80, 8'h01, 1'b1);
    chk("lt_signed", 32'(out_result), 32'h01);
    issue(4'h9, 8'h5A, 8'h5A, 1'b0);
    chk("eq_result", 32'(out_result), 32'h01);
`ifndef ALU_PIPE_DIV_EN
    issue(4'hD, 8'h64, 8'h07, 1'b0);
    chk("pass_d_result", 32'(out_result), 32'h64);
    chk("pass_d_flags", 32'(out_flags), 32'b0000);
`endif
    @(negedge clk);

    issue(4'h2, 8'h12, 8'h0D, 1'b0);
    wait_result(lat, rdy_hi);
    chk("mul1_latency", 32'(lat), 32'd9);
    chk("mul1_in_ready_busy", 32'(rdy_hi), 32'd0);
    chk("mul1_result", 32'(out_result), 32'hEA);
    chk("mul1_flags", 32'(out_flags), 32'b1000);
    issue(4'h2, 8'h20, 8'h10, 1'b0);
    wait_result(lat, rdy_hi);
    chk("mul2_latency", 32'(lat), 32'd9);
    chk("mul2_result", 32'(out_result), 32'h00);
    chk("mul2_flags", 32'(out_flags), 32'b0011);
    @(negedge clk);

    out_ready = 1'b0;
    issue(4'h0, 8'h03, 8'h04, 1'b0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_result", 32'(out_result), 32'h07);
      chk("bp_hold_flags", 32'(out_flags), 32'b0000);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    op = 4'h1; in_a = 8'h09; in_b = 8'h03; in_signed = 1'b0; in_valid = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_result", 32'(out_result), 32'h06);
    @(negedge clk);

    issue(4'h2, 8'hFF, 8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", 32'(out_result), 32'h00);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_stale_mul", 32'(seen), 32'd0);

`ifdef ALU_PIPE_DIV_EN
    issue(4'hD, 8'h64, 8'h07, 1'b0);
    wait_result(lat, rdy_hi);
    chk("div_latency", 32'(lat), 32'd9);
    chk("div_busy_ready", 32'(rdy_hi), 32'd0);
    chk("div_result", 32'(out_result), 32'h0E);
    chk("div_flags", 32'(out_flags), 32'b0000);
    issue(4'hE, 8'h64, 8'h07, 1'b0);
    wait_result(lat, rdy_hi);
    chk("rem_latency", 32'(lat), 32'd9);
    chk("rem_result", 32'(out_result), 32'h02);
    issue(4'hD, 8'h64, 8'h00, 1'b0);
    wait_result(lat, rdy_hi);
    chk("div0_latency", 32'(lat), 32'd9);
    chk("div0_result", 32'(out_result), 32'hFF);
    chk("div0_flags", 32'(out_flags), 32'b1010);
    issue(4'hE, 8'h64, 8'h00, 1'b0);
    wait_result(lat, rdy_hi);
    chk("rem0_result", 32'(out_result), 32'h64);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
